// File: rtl/clock_div_prog.sv
// Programmable integer clock divider with 50% duty for even and odd divisors.
// Divisor updates are shadowed and applied only at a period boundary; tick marks each period start.
`timescale 1ns/1ps
module clock_div_prog #(
  parameter int unsigned W       = 8,
  parameter int unsigned DIV_RST = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         div_load,
  output logic         div_pending,
  output logic         div_err,
  output logic [W-1:0] div_active,
  output logic         tick,
  output logic         clk_out
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [W-1:0] DIV_MIN  = W'(2);
  localparam logic [W-1:0] DIV_INIT = W'(DIV_RST);

  state_t       state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic [W-1:0] shadow, shadow_nxt;
  logic [W-1:0] active_nxt;
  logic [W-1:0] h;
  logic         q_pos, q_pos_nxt, q_neg;
  logic         pend_nxt, err_nxt, tick_nxt;
  logic         boundary;

  // High-phase length in posedge cycles: ceil(D/2), computed one bit wider so D=2**W-1 cannot wrap
  assign h        = W'(({1'b0, div_active} + {{W{1'b0}}, 1'b1}) >> 1);
  assign boundary = (state == RUN) && (cnt == div_active - W'(1));

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    q_pos_nxt  = q_pos;
    tick_nxt   = 1'b0;
    active_nxt = div_active;
    pend_nxt   = div_pending;
    shadow_nxt = shadow;
    err_nxt    = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt   = '0;
        q_pos_nxt = 1'b0;
        if (en) begin
          if (div_pending) begin
            active_nxt = shadow;
            pend_nxt   = 1'b0;
          end
          q_pos_nxt = 1'b1;
          tick_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (boundary) begin
          cnt_nxt = '0;
          if (div_pending) begin
            active_nxt = shadow;
            pend_nxt   = 1'b0;
          end
          if (en) begin
            q_pos_nxt = 1'b1;
            tick_nxt  = 1'b1;
          end else begin
            q_pos_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt   = cnt + W'(1);
          q_pos_nxt = (cnt_nxt < h);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A load on the boundary edge re-arms pending after the apply above, so it waits a period
    if (div_load) begin
      shadow_nxt = (div_in < DIV_MIN) ? DIV_MIN : div_in;
      pend_nxt   = 1'b1;
      err_nxt    = (div_in < DIV_MIN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      q_pos       <= 1'b0;
      div_active  <= DIV_INIT;
      shadow      <= DIV_INIT;
      div_pending <= 1'b0;
      div_err     <= 1'b0;
      tick        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      q_pos       <= q_pos_nxt;
      div_active  <= active_nxt;
      shadow      <= shadow_nxt;
      div_pending <= pend_nxt;
      div_err     <= err_nxt;
      tick        <= tick_nxt;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) q_neg <= 1'b0;
    else     q_neg <= q_pos;
  end

  // Odd divisors delay the rising edge by half a clk via q_neg; q_pos low still drops clk_out at once
  assign clk_out = div_active[0] ? (q_pos & q_neg) : q_pos;

endmodule
